// File: rtl/equivalence_comparator_pkg.sv
// Shared types and helpers for the equivalence comparator family.
package equivalence_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } eqseq_state_t;

    // Width of a counter that can hold 0..(width/chunk) slices.
    function automatic int unsigned calc_cnt_width(input int unsigned width,
                                                   input int unsigned chunk);
        return $clog2(width / chunk + 1);
    endfunction

endpackage

// File: rtl/equivalence_comparator_base.sv
// Narrow single-cycle equality comparator.
module equivalence_comparator_base #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/equivalence_comparator_sequencer.sv
// Multi-cycle wide equality comparator: one CHUNK-bit slice per cycle, LSB slice first.
module equivalence_comparator_sequencer
    import equivalence_comparator_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHUNK      = 8,
    parameter bit          EARLY_EXIT = 1'b1,
    localparam int unsigned N         = WIDTH / CHUNK,
    localparam int unsigned CW        = calc_cnt_width(WIDTH, CHUNK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    output logic             i_rdy,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_vld,
    input  logic             o_rdy,
    output logic             o_eq,
    output logic [CW-1:0]    o_cnt
);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end

    eqseq_state_t     state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             match_q, match_d;
    logic             eq_q, eq_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic             slice_eq;

    // Select the slice under test from the latched operands.
    assign a_slice = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_slice = b_q[int'(idx_q) * CHUNK +: CHUNK];

    equivalence_comparator_base #(
        .WIDTH (CHUNK)
    ) u_slice_cmp (
        .a  (a_slice),
        .b  (b_slice),
        .eq (slice_eq)
    );

    // Handshake outputs depend only on state (and rst for i_rdy), never on the peer's signal.
    assign i_rdy = (state_q == IDLE) && !rst;
    assign o_vld = (state_q == DONE);
    assign o_eq  = eq_q;
    assign o_cnt = cnt_q;

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        match_d = match_q;
        eq_d    = eq_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_vld && i_rdy) begin
                    state_d = RUN;
                    a_d     = i_a;
                    b_d     = i_b;
                    idx_d   = '0;
                    match_d = 1'b1;
                end
            end
            RUN: begin
                if (!slice_eq) begin
                    match_d = 1'b0;
                end
                if (EARLY_EXIT && !slice_eq) begin
                    state_d = DONE;
                    eq_d    = 1'b0;
                    cnt_d   = idx_q + CW'(1);
                end else if (idx_q == CW'(N - 1)) begin
                    state_d = DONE;
                    eq_d    = match_q && slice_eq;
                    cnt_d   = CW'(N);
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            DONE: begin
                if (o_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            match_q <= 1'b0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            match_q <= match_d;
            eq_q    <= eq_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_equivalence_comparator_sequencer.sv
// Self-checking bench: one early-exit and one constant-latency instance, WIDTH=32, CHUNK=8.
module tb_equivalence_comparator_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        ordy [2];
    logic        oeq  [2];
    logic [31:0] ia   [2];
    logic [31:0] ib   [2];
    logic [2:0]  ocnt [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int prev_acc = -1;
    int prev_lat = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    equivalence_comparator_sequencer #(
        .WIDTH      (32),
        .CHUNK      (8),
        .EARLY_EXIT (1'b1)
    ) u_dut_ee (
        .clk   (clk),
        .rst   (rst),
        .i_vld (iv[0]),
        .i_rdy (ir[0]),
        .i_a   (ia[0]),
        .i_b   (ib[0]),
        .o_vld (ov[0]),
        .o_rdy (ordy[0]),
        .o_eq  (oeq[0]),
        .o_cnt (ocnt[0])
    );

    equivalence_comparator_sequencer #(
        .WIDTH      (32),
        .CHUNK      (8),
        .EARLY_EXIT (1'b0)
    ) u_dut_full (
        .clk   (clk),
        .rst   (rst),
        .i_vld (iv[1]),
        .i_rdy (ir[1]),
        .i_a   (ia[1]),
        .i_b   (ib[1]),
        .o_vld (ov[1]),
        .o_rdy (ordy[1]),
        .o_eq  (oeq[1]),
        .o_cnt (ocnt[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Slices examined: N for equal operands or full-compare mode, else first differing slice + 1.
    function automatic int ref_cnt(input logic [31:0] a, input logic [31:0] b, input bit ee);
        if (a == b || !ee) return 4;
        for (int j = 0; j < 4; j++) begin
            if (a[j*8 +: 8] != b[j*8 +: 8]) return j + 1;
        end
        return 4;
    endfunction

    // One transaction on instance u; hold = cycles of o_rdy=0 after o_vld, keep = leave i_vld high.
    task automatic txn(input int u, input logic [31:0] a, input logic [31:0] b, input int hold,
                       input bit keep, input bit chk_rate);
        int   guard;
        int   t;
        int   lat;
        int   exp_cnt;
        logic exp_eq;
        exp_eq  = (a == b);
        exp_cnt = ref_cnt(a, b, u == 0);
        ordy[u] = (hold == 0);
        ia[u]   = a;
        ib[u]   = b;
        iv[u]   = 1'b1;
        guard   = 0;
        while (!ir[u] && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("accept_rdy", 32'(ir[u]), 32'd1);
        @(posedge clk);
        #1;
        t = cyc;
        if (chk_rate && prev_acc >= 0) check("rate", 32'(t - prev_acc), 32'(prev_lat + 2));
        prev_acc = t;
        prev_lat = exp_cnt;
        if (!keep) iv[u] = 1'b0;
        // Operand changes after acceptance must not affect the result.
        ia[u] = $urandom;
        ib[u] = $urandom;
        lat = 0;
        while (!ov[u] && lat < 20) begin
            check("rdy_busy", 32'(ir[u]), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_cnt));
        check("eq", 32'(oeq[u]), 32'(exp_eq));
        check("cnt", 32'(ocnt[u]), 32'(exp_cnt));
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("bp_vld", 32'(ov[u]), 32'd1);
                check("bp_eq", 32'(oeq[u]), 32'(exp_eq));
                check("bp_cnt", 32'(ocnt[u]), 32'(exp_cnt));
                check("bp_rdy", 32'(ir[u]), 32'd0);
            end
            ordy[u] = 1'b1;
            @(posedge clk);
            #1;
            check("release_vld", 32'(ov[u]), 32'd0);
            check("release_rdy", 32'(ir[u]), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
            ia[k]   = '0;
            ib[k]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 32'(ir[0]), 32'd0);
        check("rst_vld", 32'(ov[0]), 32'd0);
        check("rst_eq", 32'(oeq[0]), 32'd0);
        check("rst_cnt", 32'(ocnt[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 32'(ir[0]), 32'd1);

        // Directed cases.
        txn(0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        txn(0, 32'h12345678, 32'h12345679, 0, 1'b0, 1'b0);
        txn(1, 32'h12345678, 32'h12345679, 0, 1'b0, 1'b0);
        txn(0, 32'h00000000, 32'h80000000, 0, 1'b0, 1'b0);
        txn(1, 32'h00FF0000, 32'h00000000, 0, 1'b0, 1'b0);
        txn(0, 32'hCAFEF00D, 32'hCAFEF00D, 6, 1'b0, 1'b0);
        txn(0, 32'hCAFE000D, 32'hCAFEF00D, 3, 1'b0, 1'b0);
        txn(0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1'b0, 1'b0);

        // Reset mid-RUN aborts the transaction and clears the result registers.
        @(posedge clk);
        #1;
        ia[0]   = 32'h55AA55AA;
        ib[0]   = 32'h55AA55AA;
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        check("pre_abort_rdy", 32'(ir[0]), 32'd1);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_vld", 32'(ov[0]), 32'd0);
        check("abort_eq", 32'(oeq[0]), 32'd0);
        check("abort_cnt", 32'(ocnt[0]), 32'd0);
        check("abort_rdy", 32'(ir[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_rdy_release", 32'(ir[0]), 32'd1);
        txn(0, 32'h0BADF00D, 32'h0BADF00D, 0, 1'b0, 1'b0);

        // Back-to-back random pairs with i_vld and o_rdy held high.
        prev_acc = -1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            case (i % 3)
                0:       b = a;
                1:       b = a ^ (32'h1 << $urandom_range(31, 0));
                default: b = $urandom;
            endcase
            txn(0, a, b, 0, 1'b1, 1'b1);
        end
        iv[0] = 1'b0;
        prev_acc = -1;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? a : (a ^ (32'h1 << $urandom_range(31, 0)));
            txn(1, a, b, 0, 1'b1, 1'b1);
        end
        iv[1] = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/equivalence_comparator_sequencer.md
# equivalence_comparator_sequencer

Multi-cycle equality comparator for wide operands. Accepts one operand pair over a valid/ready handshake, registers it, and compares it in CHUNK-bit slices, LSB slice first, over up to WIDTH/CHUNK cycles through a single narrow equivalence comparator. It returns the equality result, and the number of slices examined, over a second valid/ready handshake. It trades latency for comparator area where WIDTH is large.

## Interface
- WIDTH, 32: operand width in bits.
- CHUNK, 8: slice width compared per cycle. WIDTH % CHUNK == 0 is required; elaboration fails otherwise.
- EARLY_EXIT, 1: 1 finishes at the first mismatching slice; 0 always examines all slices (constant latency).
- Derived: N = WIDTH/CHUNK; CW = $clog2(N+1).

Ports (name, direction, width, meaning):
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- i_vld  input  1  operand pair valid.
- i_rdy  output  1  sequencer can accept an operand pair.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- o_vld  output  1  result valid.
- o_rdy  input  1  consumer accepts the result.
- o_eq  output  1  1 when A == B.
- o_cnt  output  CW  number of slices examined, 1..N.

## Operation
- States:
  - IDLE: i_rdy=1. The state moves to RUN on i_vld&&i_rdy; i_a and i_b are latched, the slice index is cleared, and the match flag is set to 1.
  - RUN: compares slice idx, bits [idx*CHUNK +: CHUNK] of the latched A and B.
    - Slice mismatch: clear the match flag.
    - EARLY_EXIT=1 and mismatch: go to DONE with o_eq=0 and o_cnt=idx+1.
    - idx==N-1: go to DONE with o_eq=match&&slice_eq and o_cnt=N.
    - Otherwise: increment idx.
  - DONE: o_vld=1. o_eq and o_cnt are held stable. On o_rdy the state moves to IDLE.
- i_rdy is 1 only in IDLE and only while rst is low. o_vld is 1 only in DONE.
- i_a and i_b are ignored outside the accepting handshake; changes during RUN or DONE have no effect.
- Output rules:
  - o_eq and o_cnt are registers, updated only on the RUN→DONE transition.
  - Between results they keep their last values.
- Reset values: state IDLE, o_vld=0, o_eq=0, o_cnt=0, idx=0, latched operands 0.
- Reset asserted in any state, including mid-RUN or in DONE with o_vld high, aborts the transaction. The result is discarded and never presented.
- N=1 (CHUNK==WIDTH) is legal: RUN lasts exactly one cycle.

## Timing
- Accept on rising edge t (IDLE, i_vld=1).
  - The cycle after edge t+k compares slice k.
- Full compare (match, or EARLY_EXIT=0): o_vld rises after edge t+N. Latency is N cycles.
- Early exit at first mismatch in slice j: o_vld rises after edge t+j+1, with o_cnt=j+1.
- Result handshake completes on the edge where o_vld&&o_rdy. The state is IDLE after that edge; the next accept is possible one edge later.
- Maximum throughput with i_vld and o_rdy held high: one result per N+2 cycles for a full compare, j+3 cycles for early exit at slice j.
- Backpressure: o_vld, o_eq and o_cnt hold indefinitely while o_rdy=0; i_rdy stays 0.
- No combinational path from i_vld to i_rdy, or from o_rdy to o_vld.
- The deassertion cycle of rst is the first cycle with i_rdy=1.

## Structure
- Package equivalence_comparator_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} eqseq_state_t.
  - Function for deriving CW from WIDTH and CHUNK, shared with future comparator blocks.
- Sub-module: one instance of equivalence_comparator_base with WIDTH=CHUNK.
  - Driven by the slices of the latched operands selected by idx; its eq feeds the state machine.
  - No other comparator logic in this block.

## Test plan
All scenarios use WIDTH=32 and CHUNK=8, so N=4 and CW=3.
1. A=B=32'hDEADBEEF, o_rdy=1 → o_vld after edge t+4, o_eq=1, o_cnt=4, i_rdy=0 during t..t+5.
2. A=32'h12345678, B=32'h12345679, EARLY_EXIT=1 → o_vld after edge t+1, o_eq=0, o_cnt=1. Same stimulus with EARLY_EXIT=0 → o_vld after edge t+4, o_eq=0, o_cnt=4.
3. A=32'h00000000, B=32'h80000000 (top slice differs) → o_vld after edge t+4, o_eq=0, o_cnt=4. Toggling i_a and i_b during RUN does not change the result.
4. Hold o_rdy=0 for 6 cycles after o_vld rises → o_vld, o_eq and o_cnt stable, i_rdy=0 throughout. Then o_rdy=1 → IDLE next edge.
5. Assert rst for 1 cycle at t+2 mid-RUN → next cycle o_vld=0, o_eq=0, o_cnt=0. A following match transaction returns o_eq=1, o_cnt=4 with no stale result presented.
6. i_vld and o_rdy held high with 8 random pairs, including equal pairs → one result every 6 cycles for full compares. o_eq and o_cnt match a reference model for every pair.
